register_file_sb: RTL

Parametrised multi-port integer register file with a per-register pending-write scoreboard, the successor to the fixed 2-read/1-write, 32×32 register file in the RV core datapath. It sits between decode (read addresses, busy checks, scoreboard set at issue) and writeback (write port, scoreboard clear). Register 0 is hardwired to zero. An optional same-cycle write-to-read bypass is selected per instance.

---
 rtl/rf_pkg.sv | 13 +
 rtl/rf_scoreboard.sv | 51 +++++
 rtl/register_file_sb.sv | 82 ++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Holds the default data width, the zero register index and port slicing.
package rf_pkg;

    localparam int XLEN_DEF = 32;
    localparam int ZERO_REG = 0;

    // Low bit of port k inside a flattened bus of w-bit fields.
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a busy counter.
// Ports: clk, rst, wen/wnum (clear), sen/snum (set), busy vector, busy_cnt.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wen,
    input  logic [AW-1:0]             wnum,
    input  logic                      sen,
    input  logic [AW-1:0]             snum,
    output logic [NREG-1:0]           busy,
    output logic [$clog2(NREG+1)-1:0] busy_cnt
);

    localparam int CW = $clog2(NREG + 1);
    localparam logic [AW:0] NREG_W = (AW + 1)'(NREG);

    logic [NREG-1:0] busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            set_ok, clr_ok, inc, dec;

    always_comb begin
        set_ok = sen && (snum != AW'(ZERO_REG)) && ({1'b0, snum} < NREG_W);
        clr_ok = wen && (wnum != AW'(ZERO_REG)) && ({1'b0, wnum} < NREG_W);
        busy_d = busy_q;
        if (clr_ok) busy_d[wnum] = 1'b0;
        // A set to the same register lands after the clear: new producer wins.
        if (set_ok) busy_d[snum] = 1'b1;
        inc = set_ok && !busy_q[snum];
        dec = clr_ok && busy_q[wnum] && !(set_ok && (snum == wnum));
        cnt_d = cnt_q + CW'(inc) - CW'(dec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = cnt_q;

endmodule

// File: rtl/register_file_sb.sv
// Multi-port integer register file with pending-write scoreboard, reg 0 = 0.
// Ports: Rnum/Rd/Rbusy (NRD reads), Wen/Wnum/Wd (write), Sen/Snum, busy_cnt.
module register_file_sb
    import rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NRD*$clog2(NREG)-1:0]   Rnum,
    output logic [NRD*XLEN-1:0]           Rd,
    output logic [NRD-1:0]                Rbusy,
    input  logic                          Wen,
    input  logic [$clog2(NREG)-1:0]       Wnum,
    input  logic [XLEN-1:0]               Wd,
    input  logic                          Sen,
    input  logic [$clog2(NREG)-1:0]       Snum,
    output logic [$clog2(NREG+1)-1:0]     busy_cnt
);

    localparam int AW = $clog2(NREG);
    localparam logic [AW:0] NREG_W = (AW + 1)'(NREG);

    logic [NREG-1:1][XLEN-1:0] mem_q, mem_d;
    logic [NREG-1:0]           busy;
    logic                      w_ok;

    always_comb begin
        w_ok  = Wen && (Wnum != AW'(ZERO_REG)) && ({1'b0, Wnum} < NREG_W);
        mem_d = mem_q;
        if (w_ok) mem_d[Wnum] = Wd;
    end

    always_ff @(posedge clk) begin
        if (rst) mem_q <= '0;
        else     mem_q <= mem_d;
    end

    rf_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .wen      (Wen),
        .wnum     (Wnum),
        .sen      (Sen),
        .snum     (Snum),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   rn;
        logic [XLEN-1:0] rdat;
        logic            rbsy, r_ok, fwd;

        assign rn = Rnum[slice_lo(k, AW) +: AW];

        always_comb begin
            r_ok = (rn != AW'(ZERO_REG)) && ({1'b0, rn} < NREG_W);
            fwd  = (BYPASS != 0) && w_ok && (Wnum == rn);
            rdat = '0;
            rbsy = 1'b0;
            // Forwarded data retires its producer unless a new one issues now.
            if (fwd) begin
                rdat = Wd;
                rbsy = Sen && (Snum == rn);
            end else if (r_ok) begin
                rdat = mem_q[rn];
                rbsy = busy[rn];
            end
        end

        assign Rd[slice_lo(k, XLEN) +: XLEN] = rdat;
        assign Rbusy[k] = rbsy;
    end

endmodule
